// File: rtl/serial_word_receiver_pkg.sv
// Shared definitions for the serial word link: FSM state encodings and
// parity-mode constants, used by both the receive and transmit sides.
package serial_word_receiver_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Number of serial bits in one frame: data bits plus an optional parity bit.
  function automatic int frame_bits(input int width, input int parity);
    return width + ((parity != PAR_NONE) ? 1 : 0);
  endfunction

endpackage

// File: rtl/serial_word_receiver_if.sv
// Serial-in / parallel-out handshake bundle of the word receiver.
// master = link/consumer side, slave = receiver.
interface serial_word_receiver_if #(
  parameter int WIDTH = 4
) ();

  logic             serial_in;
  logic             bit_valid;
  logic             frame_start;
  logic             out_ready;
  logic             clr_overrun;
  logic [WIDTH-1:0] parallel_Q;
  logic             word_valid;
  logic             parity_err;
  logic             busy;
  logic             overrun;

  modport master (
    output serial_in, bit_valid, frame_start, out_ready, clr_overrun,
    input  parallel_Q, word_valid, parity_err, busy, overrun
  );

  modport slave (
    input  serial_in, bit_valid, frame_start, out_ready, clr_overrun,
    output parallel_Q, word_valid, parity_err, busy, overrun
  );

endinterface

// File: rtl/serial_word_receiver_sipo_shift_core.sv
// Serial-in parallel-out shift register with selectable fill direction.
// data_d exposes the next register value so the caller can capture a word
// on the same edge that shifts in its final bit.
module sipo_shift_core
  import serial_word_receiver_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data_q,
  output logic [WIDTH-1:0] data_d
);

  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] shifted;

  // A clear and a shift in the same cycle shift into an empty register.
  assign base = clr ? '0 : data_q;

  genvar gi;
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      // Bits enter at [0] and move up; the first bit ends at [WIDTH-1].
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (gi == 0) begin : g_in
          assign shifted[gi] = bit_in;
        end else begin : g_mv
          assign shifted[gi] = base[gi-1];
        end
      end
    end else begin : g_lsb_first
      // Bits enter at [WIDTH-1] and move down; the first bit ends at [0].
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (gi == WIDTH - 1) begin : g_in
          assign shifted[gi] = bit_in;
        end else begin : g_mv
          assign shifted[gi] = base[gi+1];
        end
      end
    end
  endgenerate

  // Next-state selection: shift, clear, or hold.
  always_comb begin
    data_d = shift_en ? shifted : base;
  end

  // Shift register storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/serial_word_receiver.sv
// Framed serial-to-parallel word receiver with optional parity check,
// valid/ready output handshake and sticky overrun flag.
module serial_word_receiver
  import serial_word_receiver_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 0,
  parameter int PARITY    = PAR_NONE
) (
  input logic                clk,
  input logic                rst,
  serial_word_receiver_if.slave bus
);

  localparam int FRAME_LEN = frame_bits(WIDTH, PARITY);
  localparam int CW        = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] DATA_BITS = CW'(WIDTH);
  localparam logic ODD_FLIP   = (PARITY == PAR_ODD);
  localparam logic PAR_ACTIVE = (PARITY != PAR_NONE);

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic             par_acc_reg;
  logic [WIDTH-1:0] parallel_q_reg;
  logic             word_valid_reg;
  logic             parity_err_reg;
  logic             overrun_reg;

  logic             bit_take;
  logic [CW-1:0]    cnt_base;
  logic             par_base;
  logic             is_data;
  logic             last_bit;
  logic             par_next;
  logic             err_next;
  logic             drop;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  // Frame bookkeeping: a frame_start restarts counting from bit 0, and a bit
  // presented with it already belongs to the new frame.
  always_comb begin
    bit_take = bus.bit_valid && (bus.frame_start || (state_reg == ST_SHIFT));
    cnt_base = bus.frame_start ? '0 : cnt_reg;
    par_base = bus.frame_start ? 1'b0 : par_acc_reg;
    is_data  = (cnt_base < DATA_BITS);
    last_bit = bit_take && (cnt_base == LAST_IDX);
    par_next = par_base ^ (is_data & bus.serial_in);
    // Only meaningful on the parity bit itself, where par_base holds the data XOR.
    err_next = PAR_ACTIVE & (par_base ^ bus.serial_in ^ ODD_FLIP);
    drop     = last_bit && word_valid_reg && !bus.out_ready;
  end

  sipo_shift_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .clr     (bus.frame_start),
    .shift_en(bit_take && is_data),
    .bit_in  (bus.serial_in),
    .data_q  (shift_q),
    .data_d  (shift_d)
  );

  // FSM, bit counter, parity accumulator, output register and overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      par_acc_reg    <= 1'b0;
      parallel_q_reg <= '0;
      word_valid_reg <= 1'b0;
      parity_err_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      if (bit_take) begin
        if (last_bit) begin
          state_reg   <= ST_IDLE;
          cnt_reg     <= '0;
          par_acc_reg <= 1'b0;
        end else begin
          state_reg   <= ST_SHIFT;
          cnt_reg     <= cnt_base + 1'b1;
          par_acc_reg <= par_next;
        end
      end else if (bus.frame_start) begin
        state_reg   <= ST_SHIFT;
        cnt_reg     <= '0;
        par_acc_reg <= 1'b0;
      end

      // A completing frame either replaces the word or is dropped when the
      // consumer is still holding off the previous one.
      if (last_bit && !drop) begin
        parallel_q_reg <= shift_d;
        parity_err_reg <= err_next;
        word_valid_reg <= 1'b1;
      end else if (word_valid_reg && bus.out_ready) begin
        word_valid_reg <= 1'b0;
      end

      // Setting wins over a simultaneous clear.
      if (drop) begin
        overrun_reg <= 1'b1;
      end else if (bus.clr_overrun) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign bus.parallel_Q = parallel_q_reg;
  assign bus.word_valid = word_valid_reg;
  assign bus.parity_err = parity_err_reg;
  assign bus.busy       = (state_reg == ST_SHIFT);
  assign bus.overrun    = overrun_reg;

  // shift_q is kept visible for debug; the captured word comes from shift_d.
  logic unused_shift_q;
  assign unused_shift_q = ^shift_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: four instances (LSB-first,
// MSB-first, even parity, odd parity) share one stimulus stream.
module tb_serial_word_receiver;

  logic clk = 1'b0;
  logic rst;
  logic serial_in;
  logic bit_valid;
  logic frame_start;
  logic out_ready;
  logic clr_overrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_word_receiver_if #(.WIDTH(4)) if0 ();
  serial_word_receiver_if #(.WIDTH(4)) if1 ();
  serial_word_receiver_if #(.WIDTH(4)) if2 ();
  serial_word_receiver_if #(.WIDTH(4)) if3 ();

  assign if0.serial_in = serial_in;   assign if0.bit_valid = bit_valid;
  assign if0.frame_start = frame_start; assign if0.out_ready = out_ready;
  assign if0.clr_overrun = clr_overrun;
  assign if1.serial_in = serial_in;   assign if1.bit_valid = bit_valid;
  assign if1.frame_start = frame_start; assign if1.out_ready = out_ready;
  assign if1.clr_overrun = clr_overrun;
  assign if2.serial_in = serial_in;   assign if2.bit_valid = bit_valid;
  assign if2.frame_start = frame_start; assign if2.out_ready = out_ready;
  assign if2.clr_overrun = clr_overrun;
  assign if3.serial_in = serial_in;   assign if3.bit_valid = bit_valid;
  assign if3.frame_start = frame_start; assign if3.out_ready = out_ready;
  assign if3.clr_overrun = clr_overrun;

  serial_word_receiver #(.WIDTH(4), .MSB_FIRST(0), .PARITY(0)) d0 (.clk(clk), .rst(rst), .bus(if0));
  serial_word_receiver #(.WIDTH(4), .MSB_FIRST(1), .PARITY(0)) d1 (.clk(clk), .rst(rst), .bus(if1));
  serial_word_receiver #(.WIDTH(4), .MSB_FIRST(0), .PARITY(1)) d2 (.clk(clk), .rst(rst), .bus(if2));
  serial_word_receiver #(.WIDTH(4), .MSB_FIRST(0), .PARITY(2)) d3 (.clk(clk), .rst(rst), .bus(if3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic fs);
    frame_start = fs;
    bit_valid   = 1'b1;
    serial_in   = b;
    tick();
    frame_start = 1'b0;
    bit_valid   = 1'b0;
    serial_in   = 1'b0;
  endtask

  // bits[k] is frame bit k; gap idle cycles are inserted between data bits.
  task automatic send_frame(input logic [3:0] bits, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_bit(bits[i], (i == 0));
      if (i < 3) repeat (gap) tick();
    end
  endtask

  initial begin
    rst = 1'b1; serial_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
    out_ready = 1'b0; clr_overrun = 1'b0;
    tick(); tick();
    check("rst_q",       8'(if0.parallel_Q), 8'h0);
    check("rst_valid",   8'(if0.word_valid), 8'h0);
    check("rst_busy",    8'(if0.busy),       8'h0);
    check("rst_overrun", 8'(if0.overrun),    8'h0);
    check("rst_perr",    8'(if2.parity_err), 8'h0);
    rst = 1'b0;
    tick();

    // 1: LSB-first 1,1,1,0 -> 0111; latency and handshake
    send_bit(1'b1, 1'b1);
    check("t1_busy", 8'(if0.busy), 8'h1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("t1_not_yet", 8'(if0.word_valid), 8'h0);
    send_bit(1'b0, 1'b0);
    $display("t1 frame 1,1,1,0: q=%b valid=%b", if0.parallel_Q, if0.word_valid);
    check("t1_valid",    8'(if0.word_valid), 8'h1);
    check("t1_q",        8'(if0.parallel_Q), 8'h07);
    check("t1_idle",     8'(if0.busy),       8'h0);
    check("t1_msb_q",    8'(if1.parallel_Q), 8'h0E);
    check("t1_par_wait", 8'(if2.busy),       8'h1);
    check("t1_perr0",    8'(if0.parity_err), 8'h0);
    out_ready = 1'b1;
    tick();
    check("t1_consumed", 8'(if0.word_valid), 8'h0);

    // 2: MSB-first 0,1,1,1 -> 0111, with and without gaps
    send_frame(4'b1110, 0);
    $display("t2 frame 0,1,1,1: q=%b valid=%b", if1.parallel_Q, if1.word_valid);
    check("t2_q",     8'(if1.parallel_Q), 8'h07);
    check("t2_valid", 8'(if1.word_valid), 8'h1);
    check("t2_lsb_q", 8'(if0.parallel_Q), 8'h0E);
    tick();
    check("t2_consumed", 8'(if1.word_valid), 8'h0);
    send_frame(4'b1110, 3);
    $display("t2 gapped frame: q=%b valid=%b", if1.parallel_Q, if1.word_valid);
    check("t2_gap_q",     8'(if1.parallel_Q), 8'h07);
    check("t2_gap_valid", 8'(if1.word_valid), 8'h1);

    // 3: parity, data 1,0,1,1
    send_frame(4'b1101, 0);
    check("t3_wait_pbit", 8'(if2.word_valid), 8'h0);
    check("t3_busy",      8'(if2.busy),       8'h1);
    send_bit(1'b1, 1'b0);
    $display("t3 even pbit=1: q=%b perr=%b", if2.parallel_Q, if2.parity_err);
    check("t3_q",        8'(if2.parallel_Q), 8'h0D);
    check("t3_valid",    8'(if2.word_valid), 8'h1);
    check("t3_even_ok",  8'(if2.parity_err), 8'h0);
    check("t3_odd_bad",  8'(if3.parity_err), 8'h1);
    send_frame(4'b1101, 0);
    send_bit(1'b0, 1'b0);
    $display("t3 pbit=0: even perr=%b odd perr=%b", if2.parity_err, if3.parity_err);
    check("t3_even_bad", 8'(if2.parity_err), 8'h1);
    check("t3_odd_ok",   8'(if3.parity_err), 8'h0);
    tick();

    // 4: overrun with consumer stalled
    out_ready = 1'b0;
    send_frame(4'b0111, 0);
    check("t4_first_q",  8'(if0.parallel_Q), 8'h07);
    check("t4_no_ovr",   8'(if0.overrun),    8'h0);
    send_frame(4'b1010, 0);
    $display("t4 second frame dropped: q=%b overrun=%b", if0.parallel_Q, if0.overrun);
    check("t4_kept_q",   8'(if0.parallel_Q), 8'h07);
    check("t4_overrun",  8'(if0.overrun),    8'h1);
    check("t4_valid",    8'(if0.word_valid), 8'h1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("t4_cleared",  8'(if0.overrun),    8'h0);
    clr_overrun = 1'b1;
    send_frame(4'b0001, 0);
    check("t4_set_wins", 8'(if0.overrun),    8'h1);
    check("t4_kept_q2",  8'(if0.parallel_Q), 8'h07);
    tick();
    clr_overrun = 1'b0;
    check("t4_cleared2", 8'(if0.overrun),    8'h0);
    out_ready = 1'b1;
    tick();
    check("t4_drained",  8'(if0.word_valid), 8'h0);

    // 5: aborted frame then 0,0,1,1 -> 1100
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_frame(4'b1100, 0);
    $display("t5 restart frame: q=%b valid=%b", if0.parallel_Q, if0.word_valid);
    check("t5_q",     8'(if0.parallel_Q), 8'h0C);
    check("t5_valid", 8'(if0.word_valid), 8'h1);
    tick();
    check("t5_consumed", 8'(if0.word_valid), 8'h0);

    // 6: reset mid-frame and with a word pending
    out_ready = 1'b0;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_mid_busy",  8'(if0.busy),       8'h0);
    check("t6_mid_valid", 8'(if0.word_valid), 8'h0);
    send_frame(4'b0110, 0);
    check("t6_pending",   8'(if0.parallel_Q), 8'h06);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("t6 reset with word pending: q=%b valid=%b", if0.parallel_Q, if0.word_valid);
    check("t6_q0",        8'(if0.parallel_Q), 8'h0);
    check("t6_valid0",    8'(if0.word_valid), 8'h0);
    check("t6_ovr0",      8'(if0.overrun),    8'h0);
    check("t6_busy0",     8'(if0.busy),       8'h0);
    send_frame(4'b1001, 0);
    $display("t6 frame after reset: q=%b valid=%b", if0.parallel_Q, if0.word_valid);
    check("t6_after_q",     8'(if0.parallel_Q), 8'h09);
    check("t6_after_valid", 8'(if0.word_valid), 8'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
